// File: rtl/writeback_arbiter.sv
// Writeback arbiter: buffers ALU and LSU results in per-source FIFOs and issues
// at most one register-file write per cycle using round-robin arbitration.
module writeback_arbiter #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_v,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ok_o,
    input  logic            lsu_v,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ok_o,
    output logic            res_v,
    output logic [4:0]      res_adr,
    output logic [XLEN-1:0] res_data,
    output logic            last_grant_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 5 + XLEN;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [EW-1:0]   alu_mem_q [DEPTH];
    logic [EW-1:0]   lsu_mem_q [DEPTH];
    logic [PW-1:0]   alu_wptr_q, alu_wptr_d, alu_rptr_q, alu_rptr_d;
    logic [PW-1:0]   lsu_wptr_q, lsu_wptr_d, lsu_rptr_q, lsu_rptr_d;
    logic [CW-1:0]   alu_cnt_q, alu_cnt_d, lsu_cnt_q, lsu_cnt_d;
    logic            last_grant_q, last_grant_d;
    logic            res_v_q, res_v_d;
    logic [4:0]      res_adr_q, res_adr_d;
    logic [XLEN-1:0] res_data_q, res_data_d;
    logic            alu_push, lsu_push, alu_pop, lsu_pop, alu_ne, lsu_ne;
    logic [EW-1:0]   pop_entry;

    // Accept depends only on registered counts, never on this cycle's pop.
    assign alu_ok_o = (alu_cnt_q != FULL);
    assign lsu_ok_o = (lsu_cnt_q != FULL);
    assign alu_push = alu_v && alu_ok_o;
    assign lsu_push = lsu_v && lsu_ok_o;
    assign alu_ne   = (alu_cnt_q != '0);
    assign lsu_ne   = (lsu_cnt_q != '0);

    assign res_v        = res_v_q;
    assign res_adr      = res_adr_q;
    assign res_data     = res_data_q;
    assign last_grant_o = last_grant_q;

    // Arbitration: when both sources wait, grant the one not served last.
    always_comb begin
        alu_pop = 1'b0;
        lsu_pop = 1'b0;
        if (alu_ne && lsu_ne) begin
            alu_pop = last_grant_q;
            lsu_pop = !last_grant_q;
        end else begin
            alu_pop = alu_ne;
            lsu_pop = lsu_ne;
        end
    end

    always_comb begin
        alu_wptr_d = alu_wptr_q + PW'(alu_push);
        alu_rptr_d = alu_rptr_q + PW'(alu_pop);
        alu_cnt_d  = alu_cnt_q + CW'(alu_push) - CW'(alu_pop);
        lsu_wptr_d = lsu_wptr_q + PW'(lsu_push);
        lsu_rptr_d = lsu_rptr_q + PW'(lsu_pop);
        lsu_cnt_d  = lsu_cnt_q + CW'(lsu_push) - CW'(lsu_pop);
    end

    always_comb begin
        pop_entry    = alu_pop ? alu_mem_q[alu_rptr_q] : lsu_mem_q[lsu_rptr_q];
        res_v_d      = 1'b0;
        res_adr_d    = res_adr_q;
        res_data_d   = res_data_q;
        last_grant_d = last_grant_q;
        if (alu_pop || lsu_pop) begin
            // x0 entries still consume their slot but never strobe a write.
            res_v_d      = (pop_entry[EW-1 -: 5] != 5'd0);
            res_adr_d    = pop_entry[EW-1 -: 5];
            res_data_d   = pop_entry[XLEN-1:0];
            last_grant_d = lsu_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (alu_push) alu_mem_q[alu_wptr_q] <= {alu_rd, alu_data};
        if (lsu_push) lsu_mem_q[lsu_wptr_q] <= {lsu_rd, lsu_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_wptr_q   <= '0;
            alu_rptr_q   <= '0;
            alu_cnt_q    <= '0;
            lsu_wptr_q   <= '0;
            lsu_rptr_q   <= '0;
            lsu_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            res_v_q      <= 1'b0;
            res_adr_q    <= '0;
            res_data_q   <= '0;
        end else begin
            alu_wptr_q   <= alu_wptr_d;
            alu_rptr_q   <= alu_rptr_d;
            alu_cnt_q    <= alu_cnt_d;
            lsu_wptr_q   <= lsu_wptr_d;
            lsu_rptr_q   <= lsu_rptr_d;
            lsu_cnt_q    <= lsu_cnt_d;
            last_grant_q <= last_grant_d;
            res_v_q      <= res_v_d;
            res_adr_q    <= res_adr_d;
            res_data_q   <= res_data_d;
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_writeback_arbiter;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_v, lsu_v;
    logic [4:0]      alu_rd, lsu_rd;
    logic [XLEN-1:0] alu_data, lsu_data;
    logic            alu_ok_o, lsu_ok_o;
    logic            res_v;
    logic [4:0]      res_adr;
    logic [XLEN-1:0] res_data;
    logic            last_grant_o;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state: one queue of {rd, data} per source.
    logic [36:0]     exp_alu_q[$];
    logic [36:0]     exp_lsu_q[$];
    logic            m_v, m_last, m_live = 1'b0;
    logic [4:0]      m_adr;
    logic [XLEN-1:0] m_data;
    logic [36:0]     m_ent;
    logic            m_a_acc, m_l_acc, m_pick_alu, m_pick_lsu;

    writeback_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_v(alu_v), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ok_o(alu_ok_o),
        .lsu_v(lsu_v), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ok_o(lsu_ok_o),
        .res_v(res_v), .res_adr(res_adr), .res_data(res_data),
        .last_grant_o(last_grant_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: step on each edge from queue contents, then compare the DUT.
    always @(posedge clk) begin
        if (rst) begin
            exp_alu_q.delete();
            exp_lsu_q.delete();
            m_v = 1'b0; m_adr = '0; m_data = '0; m_last = 1'b1; m_live = 1'b1;
        end else if (m_live) begin
            m_a_acc    = alu_v && (exp_alu_q.size() < DEPTH);
            m_l_acc    = lsu_v && (exp_lsu_q.size() < DEPTH);
            m_pick_lsu = (exp_lsu_q.size() > 0) && ((exp_alu_q.size() == 0) || !m_last);
            m_pick_alu = (exp_alu_q.size() > 0) && !m_pick_lsu;
            m_v = 1'b0;
            if (m_pick_alu || m_pick_lsu) begin
                m_ent  = m_pick_alu ? exp_alu_q.pop_front() : exp_lsu_q.pop_front();
                m_last = m_pick_lsu;
                m_v    = (m_ent[36:32] != 5'd0);
                m_adr  = m_ent[36:32];
                m_data = m_ent[31:0];
            end
            if (m_a_acc) exp_alu_q.push_back({alu_rd, alu_data});
            if (m_l_acc) exp_lsu_q.push_back({lsu_rd, lsu_data});
        end
        #1;
        if (m_live) begin
            check("res_v", 32'(res_v), 32'(m_v));
            check("res_adr", 32'(res_adr), 32'(m_adr));
            check("res_data", res_data, m_data);
            check("last_grant", 32'(last_grant_o), 32'(m_last));
            check("alu_ok", 32'(alu_ok_o), 32'(exp_alu_q.size() != DEPTH));
            check("lsu_ok", 32'(lsu_ok_o), 32'(exp_lsu_q.size() != DEPTH));
        end
    end

    task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        @(negedge clk);
        alu_v = av; alu_rd = ard; alu_data = ad;
        lsu_v = lv; lsu_rd = lrd; lsu_data = ld;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        alu_v = 1'b0; lsu_v = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [4:0] got_q[$];
    logic [4:0] lsu_got[$];
    logic [4:0] alu_got[$];
    int         lsu_sent, alu_sent;
    logic       la, aa;

    initial begin
        rst = 1'b1;
        alu_v = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_v = 1'b0; lsu_rd = '0; lsu_data = '0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #2;
        check("rst_res_v", 32'(res_v), 32'd0);
        check("rst_res_adr", 32'(res_adr), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;
        check("idle_alu_ok", 32'(alu_ok_o), 32'd1);
        check("idle_lsu_ok", 32'(lsu_ok_o), 32'd1);
        check("idle_last_grant", 32'(last_grant_o), 32'd1);
        check("idle_res_v", 32'(res_v), 32'd0);

        // Single ALU write: visible after the second edge
        cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        check("single_e1_res_v", 32'(res_v), 32'd0);
        idle();
        check("single_res_v", 32'(res_v), 32'd1);
        check("single_res_adr", 32'(res_adr), 32'd5);
        check("single_res_data", res_data, 32'hDEADBEEF);
        check("single_model_adr", 32'(m_adr), 32'd5);
        idle();
        check("single_after_res_v", 32'(res_v), 32'd0);

        // Contention: strict alternation starting with ALU
        do_reset(1);
        cyc(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
        cyc(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
        check("cont_adr0", 32'(res_adr), 32'd1);
        check("cont_data0", res_data, 32'h11);
        check("cont_grant0", 32'(last_grant_o), 32'd0);
        idle();
        check("cont_adr1", 32'(res_adr), 32'd2);
        check("cont_grant1", 32'(last_grant_o), 32'd1);
        idle();
        check("cont_adr2", 32'(res_adr), 32'd3);
        check("cont_grant2", 32'(last_grant_o), 32'd0);
        idle();
        check("cont_adr3", 32'(res_adr), 32'd4);
        check("cont_data3", res_data, 32'h44);
        check("cont_grant3", 32'(last_grant_o), 32'd1);
        check("cont_v3", 32'(res_v), 32'd1);
        idle();
        check("cont_done_v", 32'(res_v), 32'd0);

        // x0 suppression delays the following write by one slot
        do_reset(1);
        cyc(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0);
        check("x0_res_v", 32'(res_v), 32'd0);
        idle();
        check("x0_next_v", 32'(res_v), 32'd1);
        check("x0_next_adr", 32'(res_adr), 32'd7);
        idle();
        check("x0_done_v", 32'(res_v), 32'd0);

        // Backpressure: sources hold their result until accepted
        do_reset(1);
        lsu_sent = 0; alu_sent = 0;
        got_q.delete();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            lsu_v = (lsu_sent < 3); lsu_rd = 5'(10 + lsu_sent); lsu_data = 32'h100 + 32'(lsu_sent);
            alu_v = (alu_sent < 6); alu_rd = 5'(20 + alu_sent); alu_data = 32'h200 + 32'(alu_sent);
            la = lsu_v && lsu_ok_o;
            aa = alu_v && alu_ok_o;
            @(posedge clk);
            #2;
            if (la) lsu_sent++;
            if (aa) alu_sent++;
            if (res_v) got_q.push_back(res_adr);
            if (c == 1) check("bp_lsu_full", 32'(lsu_ok_o), 32'd0);
            if (c == 2) check("bp_lsu_reopen", 32'(lsu_ok_o), 32'd1);
        end
        check("bp_total", 32'(got_q.size()), 32'd9);
        lsu_got.delete(); alu_got.delete();
        foreach (got_q[i]) begin
            if (got_q[i] < 5'd20) lsu_got.push_back(got_q[i]);
            else alu_got.push_back(got_q[i]);
        end
        check("bp_lsu_count", 32'(lsu_got.size()), 32'd3);
        check("bp_alu_count", 32'(alu_got.size()), 32'd6);
        foreach (lsu_got[i]) check("bp_lsu_order", 32'(lsu_got[i]), 32'(10 + i));
        foreach (alu_got[i]) check("bp_alu_order", 32'(alu_got[i]), 32'(20 + i));

        // Reset with entries buffered in both FIFOs
        do_reset(1);
        cyc(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2);
        cyc(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hB4);
        @(negedge clk);
        rst = 1'b1; alu_v = 1'b0; lsu_v = 1'b0;
        @(posedge clk);
        #2;
        check("midrst_res_v", 32'(res_v), 32'd0);
        check("midrst_alu_ok", 32'(alu_ok_o), 32'd1);
        check("midrst_lsu_ok", 32'(lsu_ok_o), 32'd1);
        check("midrst_grant", 32'(last_grant_o), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #2;
            check("midrst_no_stale", 32'(res_v), 32'd0);
        end

        // Randomized traffic with occasional resets
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 199) == 0);
            alu_v    = ($urandom_range(0, 2) != 0);
            alu_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            alu_data = $urandom;
            lsu_v    = ($urandom_range(0, 2) != 0);
            lsu_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            lsu_data = $urandom;
        end
        @(negedge clk);
        rst = 1'b0; alu_v = 1'b0; lsu_v = 1'b0;
        repeat (8) @(posedge clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
